dice_light_sched: RTL and testbench
===================================

// Module: dice_light_sched
// PURPOSE
//  Parametrised dice / traffic-light display controller: integrates an N-face dice, a timed
//  traffic-light sequencer and a registered output selector with four modes (dice, lights,
//  auto-scan alternating, freeze). Drives a single result bus to the board LEDs; replaces
//  the fixed 2-way dice/lights mux at the top level.
// PARAMETERS
//  FACES        6    dice faces, counts 1..FACES; legal 2..(2**RES_W)-1
//  RES_W        3    result width in bits; legal >=3
//  PHASE_CYCLES 4    clock cycles each traffic-light phase lasts; legal >=1
//  SCAN_PERIOD  8    clock cycles per source in auto-scan mode; legal >=1
// PORTS
//  clk          in   1      system clock, all logic on rising edge
//  rst          in   1      synchronous, active-high reset
//  button       in   1      dice roll: throw advances every cycle while high
//  mode         in   2      00 dice, 01 lights, 10 auto-scan, 11 freeze
//  result       out  RES_W  registered display value
//  src_light    out  1      registered: 1 when result came from the light sequencer
//  phase_start  out  1      one-cycle pulse on the first cycle of each new light phase
// BEHAVIOUR
//  Reset (rst=1 at edge): throw=1, light=RED, phase cnt=0, scan cnt=0, scan src=dice,
//   result=0, src_light=0, phase_start=0. Reset wins over every other input.
//  Dice: button=1 -> throw increments each cycle; FACES wraps to 1. button=0 -> holds.
//   Never outputs 0 or >FACES after reset.
//  Lights: fixed sequence RED(100) -> RED_AMBER(110) -> GREEN(001) -> AMBER(010) -> RED;
//   bit2=red, bit1=amber, bit0=green. Each state held exactly PHASE_CYCLES cycles
//   (phase cnt 0..PHASE_CYCLES-1, advance when cnt==PHASE_CYCLES-1). Free-running,
//   independent of mode. phase_start=1 the cycle the new state is first visible;
//   not asserted for the RED entered by reset.
//  Lights value is zero-extended to RES_W; throw is RES_W wide.
//  Selector (result/src_light updated every edge, 1-cycle latency from internal values):
//   00: result<=throw, src_light<=0.   01: result<=light, src_light<=1.
//   10: result<=scan src value; scan cnt counts 0..SCAN_PERIOD-1, src toggles at wrap.
//       On entry to 10 from any other mode, scan cnt<=0 and src<=dice that same edge.
//   11: result, src_light hold; dice and lights keep running underneath.
//  Mode change takes effect on the first edge that samples the new mode; no glitch
//   (output only ever changes on clk edge).
//  Scan cnt frozen (held) outside mode 10.
// STRUCTURE
//  Package dice_light_pkg: mode constants (MODE_DICE/LIGHT/AUTO/FREEZE), 2-bit light
//   state typedef and 3-bit RED/RED_AMBER/GREEN/AMBER lamp encodings.
//  One sub-module: tlc_timed (light FSM + phase counter, params PHASE_CYCLES, outputs
//   lamp[2:0], phase_start). Dice counter and selector stay inline.
// TESTING
//  1 rst 2 cycles, mode=01, PHASE_CYCLES=4 -> result 100 x4, 110 x4, 001 x4, 010 x4, 100;
//    phase_start pulses at cycles 4,8,12,16 after reset release.
//  2 mode=00, button high 7 cycles from reset -> throw 2,3,4,5,6,1,2; release -> result holds 2.
//  3 mode=10, SCAN_PERIOD=8 -> src_light 0 for 8 cycles, 1 for 8, 0...; result tracks source.
//  4 mode=01 then 11 mid-GREEN -> result stays 001 while lights advance; back to 01 ->
//    next edge shows current lamp state, no stale value.
//  5 rst asserted mid-roll and mid-AMBER -> next edge result=0, throw=1, light=RED, cnt=0.
//  6 FACES=7,RES_W=3 button held 20 cycles -> values only 1..7, wrap 7->1; assert never 0.

Source files
------------

// File: rtl/dice_light_pkg.sv
// Shared mode codes, light states and lamp encodings for the dice / light display.
package dice_light_pkg;

  localparam logic [1:0] MODE_DICE   = 2'b00;
  localparam logic [1:0] MODE_LIGHT  = 2'b01;
  localparam logic [1:0] MODE_AUTO   = 2'b10;
  localparam logic [1:0] MODE_FREEZE = 2'b11;

  typedef enum logic [1:0] {
    L_RED       = 2'd0,
    L_RED_AMBER = 2'd1,
    L_GREEN     = 2'd2,
    L_AMBER     = 2'd3
  } light_t;

  // Lamp bits: [2]=red, [1]=amber, [0]=green.
  localparam logic [2:0] LAMP_RED       = 3'b100;
  localparam logic [2:0] LAMP_RED_AMBER = 3'b110;
  localparam logic [2:0] LAMP_GREEN     = 3'b001;
  localparam logic [2:0] LAMP_AMBER     = 3'b010;

  function automatic logic [2:0] lamp_of(input light_t s);
    case (s)
      L_RED:       return LAMP_RED;
      L_RED_AMBER: return LAMP_RED_AMBER;
      L_GREEN:     return LAMP_GREEN;
      default:     return LAMP_AMBER;
    endcase
  endfunction

endpackage

// File: rtl/dice_light_sched_tlc_timed.sv
// Free-running timed traffic-light sequencer: each phase lasts PHASE_CYCLES clocks.
module tlc_timed
  import dice_light_pkg::*;
#(
  parameter int PHASE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  output logic [2:0] lamp,
  output logic       phase_start
);

  localparam int CNT_W = (PHASE_CYCLES > 1) ? $clog2(PHASE_CYCLES) : 1;

  light_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             wrap;

  // State, phase counter and the phase-entry pulse register.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments keep every register sampling pre-edge values.
    if (rst) begin
      state       <= L_RED;
      cnt         <= '0;
      phase_start <= 1'b0;
    end else begin
      state       <= state_next;
      cnt         <= cnt_next;
      phase_start <= wrap;
    end
  end

  // Next phase and counter; the pulse lines up with the first cycle of the new phase.
  always_comb begin
    // NOTE: defaults first so no path leaves a variable unassigned (no latch).
    state_next = state;
    cnt_next   = cnt + 1'b1;
    wrap       = (cnt == CNT_W'(PHASE_CYCLES - 1));
    if (wrap) begin
      cnt_next = '0;
      case (state)
        L_RED:       state_next = L_RED_AMBER;
        L_RED_AMBER: state_next = L_GREEN;
        L_GREEN:     state_next = L_AMBER;
        default:     state_next = L_RED;
      endcase
    end
  end

  assign lamp = lamp_of(state);

endmodule

// File: rtl/dice_light_sched.sv
// Dice / traffic-light display controller with a registered four-mode output selector.
module dice_light_sched
  import dice_light_pkg::*;
#(
  parameter int FACES        = 6,
  parameter int RES_W        = 3,
  parameter int PHASE_CYCLES = 4,
  parameter int SCAN_PERIOD  = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             button,
  input  logic [1:0]       mode,
  output logic [RES_W-1:0] result,
  output logic             src_light,
  output logic             phase_start
);

  localparam int SCAN_W = (SCAN_PERIOD > 1) ? $clog2(SCAN_PERIOD) : 1;

  logic [RES_W-1:0]  throw;
  logic [2:0]        lamp;
  logic [RES_W-1:0]  light_val;
  logic [SCAN_W-1:0] scan_cnt, scan_cnt_next;
  logic              scan_src, scan_src_next;   // 0 = dice, 1 = lights
  logic [1:0]        prev_mode;
  logic [RES_W-1:0]  result_next;
  logic              src_light_next;

  tlc_timed #(.PHASE_CYCLES(PHASE_CYCLES)) u_tlc (
    .clk         (clk),
    .rst         (rst),
    .lamp        (lamp),
    .phase_start (phase_start)
  );

  assign light_val = RES_W'(lamp);

  // Dice counter: advances while the button is held, FACES wraps back to 1.
  always_ff @(posedge clk) begin
    if (rst) begin
      throw <= RES_W'(1);
    end else if (button) begin
      throw <= (throw == RES_W'(FACES)) ? RES_W'(1) : throw + 1'b1;
    end
  end

  // Selector: picks the display source; auto-scan restarts on dice whenever entered.
  always_comb begin
    scan_cnt_next  = scan_cnt;
    scan_src_next  = scan_src;
    result_next    = result;
    src_light_next = src_light;
    case (mode)
      MODE_DICE: begin
        result_next    = throw;
        src_light_next = 1'b0;
      end
      MODE_LIGHT: begin
        result_next    = light_val;
        src_light_next = 1'b1;
      end
      MODE_AUTO: begin
        if (prev_mode != MODE_AUTO) begin
          scan_cnt_next = '0;
          scan_src_next = 1'b0;
        end else if (scan_cnt == SCAN_W'(SCAN_PERIOD - 1)) begin
          scan_cnt_next = '0;
          scan_src_next = ~scan_src;
        end else begin
          scan_cnt_next = scan_cnt + 1'b1;
        end
        // Use the post-toggle source so each source is shown exactly SCAN_PERIOD cycles.
        result_next    = scan_src_next ? light_val : throw;
        src_light_next = scan_src_next;
      end
      default: ;  // freeze: hold display, everything underneath keeps running
    endcase
  end

  // Display and scan-state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      result    <= '0;
      src_light <= 1'b0;
      scan_cnt  <= '0;
      scan_src  <= 1'b0;
      prev_mode <= MODE_DICE;
    end else begin
      result    <= result_next;
      src_light <= src_light_next;
      scan_cnt  <= scan_cnt_next;
      scan_src  <= scan_src_next;
      prev_mode <= mode;
    end
  end

endmodule

// File: tb/tb_dice_light_sched.sv
// Self-checking bench: a behavioural model pushes expected outputs, checked after each edge.
module tb_dice_light_sched;

  localparam int PC = 4;
  localparam int SP = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic       button;
  logic [1:0] mode;
  logic [2:0] result, result7;
  logic       src_light, src_light7;
  logic       phase_start, phase_start7;

  int tests_run = 0;
  int failed    = 0;

  always #5 clk = ~clk;

  dice_light_sched #(.FACES(6), .RES_W(3), .PHASE_CYCLES(PC), .SCAN_PERIOD(SP)) u_dut (
    .clk(clk), .rst(rst), .button(button), .mode(mode),
    .result(result), .src_light(src_light), .phase_start(phase_start)
  );

  dice_light_sched #(.FACES(7), .RES_W(3), .PHASE_CYCLES(PC), .SCAN_PERIOD(SP)) u_dut7 (
    .clk(clk), .rst(rst), .button(button), .mode(mode),
    .result(result7), .src_light(src_light7), .phase_start(phase_start7)
  );

  typedef struct packed {
    logic [2:0] res;
    logic       srl;
    logic       ps;
    logic [2:0] res7;
  } exp_t;

  exp_t sb[$];

  // Reference model state
  int         m_throw, m_throw7, m_li, m_pc, m_sc, m_src, m_pm;
  logic [2:0] m_res, m_res7;
  logic       m_srl, m_ps;

  function automatic logic [2:0] m_lamp(input int idx);
    case (idx)
      0:       return 3'b100;
      1:       return 3'b110;
      2:       return 3'b001;
      default: return 3'b010;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock edge of the reference behaviour, using values held before the edge.
  task automatic model_edge();
    logic [2:0] lamp_old;
    int         t_old, t7_old;
    lamp_old = m_lamp(m_li);
    t_old    = m_throw;
    t7_old   = m_throw7;
    if (rst) begin
      m_throw = 1; m_throw7 = 1; m_li = 0; m_pc = 0; m_sc = 0; m_src = 0; m_pm = 0;
      m_res = 3'd0; m_res7 = 3'd0; m_srl = 1'b0; m_ps = 1'b0;
    end else begin
      case (mode)
        2'b00: begin m_res = 3'(t_old); m_res7 = 3'(t7_old); m_srl = 1'b0; end
        2'b01: begin m_res = lamp_old; m_res7 = lamp_old; m_srl = 1'b1; end
        2'b10: begin
          if (m_pm != 2) begin m_sc = 0; m_src = 0; end
          else if (m_sc == SP - 1) begin m_sc = 0; m_src = 1 - m_src; end
          else m_sc = m_sc + 1;
          m_res  = (m_src == 1) ? lamp_old : 3'(t_old);
          m_res7 = (m_src == 1) ? lamp_old : 3'(t7_old);
          m_srl  = (m_src == 1);
        end
        default: ;
      endcase
      if (button) begin
        m_throw  = (t_old == 6) ? 1 : t_old + 1;
        m_throw7 = (t7_old == 7) ? 1 : t7_old + 1;
      end
      if (m_pc == PC - 1) begin
        m_pc = 0; m_li = (m_li + 1) % 4; m_ps = 1'b1;
      end else begin
        m_pc = m_pc + 1; m_ps = 1'b0;
      end
      m_pm = int'(mode);
    end
  endtask

  // Drive one cycle: push expected, clock, then compare just after the edge.
  task automatic step(input string tag);
    exp_t e;
    model_edge();
    sb.push_back('{res: m_res, srl: m_srl, ps: m_ps, res7: m_res7});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'd0, 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_result"},     32'(result),       32'(e.res));
      check({tag, "_src_light"},  32'(src_light),    32'(e.srl));
      check({tag, "_phase"},      32'(phase_start),  32'(e.ps));
      check({tag, "_result7"},    32'(result7),      32'(e.res7));
      check({tag, "_src_light7"}, 32'(src_light7),   32'(e.srl));
      check({tag, "_phase7"},     32'(phase_start7), 32'(e.ps));
    end
  endtask

  initial begin
    logic [2:0] lamp_tab [4];
    logic [2:0] prev7;
    int         wraps7;
    int         guard;
    lamp_tab[0] = 3'b100; lamp_tab[1] = 3'b110; lamp_tab[2] = 3'b001; lamp_tab[3] = 3'b010;

    // Reset state, lights mode selected
    rst = 1'b1; button = 1'b0; mode = 2'b01;
    m_throw = 1; m_throw7 = 1; m_li = 0; m_pc = 0; m_sc = 0; m_src = 0; m_pm = 0;
    m_res = '0; m_res7 = '0; m_srl = 1'b0; m_ps = 1'b0;
    step("rst"); step("rst");
    check("rst_result_zero", 32'(result), 32'd0);
    check("rst_phase_zero", 32'(phase_start), 32'd0);

    // 1: light sequence with PHASE_CYCLES=4
    rst = 1'b0;
    for (int k = 1; k <= 17; k++) begin
      step("t1");
      check("t1_lamp_seq", 32'(result), 32'(lamp_tab[((k - 1) / 4) % 4]));
      check("t1_phase_pulse", 32'(phase_start), (k % 4 == 0) ? 32'd1 : 32'd0);
    end

    // 2: dice roll from reset, then hold
    rst = 1'b1; step("t2_rst");
    rst = 1'b0; mode = 2'b00; button = 1'b1;
    for (int k = 1; k <= 7; k++) begin
      step("t2_roll");
      check("t2_roll_seq", 32'(result), 32'(((k - 1) % 6) + 1));
    end
    button = 1'b0;
    step("t2_hold"); check("t2_hold_a", 32'(result), 32'd2);
    step("t2_hold"); check("t2_hold_b", 32'(result), 32'd2);

    // 3: auto-scan alternates every 8 cycles, starting on dice
    mode = 2'b10;
    for (int k = 1; k <= 24; k++) begin
      step("t3");
      check("t3_scan_src", 32'(src_light), 32'(((k - 1) / 8) % 2));
    end

    // 4: freeze mid-GREEN, then back to lights
    mode = 2'b01;
    guard = 0;
    while (!(m_li == 2 && m_pc == 1) && guard < 32) begin
      step("t4_seek"); guard++;
    end
    check("t4_seek_bound", (guard < 32) ? 32'd1 : 32'd0, 32'd1);
    step("t4_green");
    check("t4_green", 32'(result), 32'b001);
    mode = 2'b11;
    for (int k = 0; k < 10; k++) begin
      step("t4_freeze");
      check("t4_freeze_hold", 32'(result), 32'b001);
    end
    mode = 2'b01;
    step("t4_resume");

    // 5: reset mid-roll and mid-AMBER
    mode = 2'b00; button = 1'b1;
    guard = 0;
    while (!(m_li == 3 && m_pc == 1) && guard < 32) begin
      step("t5_seek"); guard++;
    end
    check("t5_seek_bound", (guard < 32) ? 32'd1 : 32'd0, 32'd1);
    rst = 1'b1; step("t5_rst");
    check("t5_result_zero", 32'(result), 32'd0);
    rst = 1'b0; button = 1'b0; mode = 2'b01;
    step("t5_after");
    check("t5_light_red", 32'(result), 32'b100);
    mode = 2'b00;
    step("t5_dice");
    check("t5_throw_one", 32'(result), 32'd1);

    // 6: FACES=7 never shows 0 or >7 and wraps 7->1
    rst = 1'b1; step("t6_rst");
    rst = 1'b0; mode = 2'b00; button = 1'b1;
    prev7 = 3'd0; wraps7 = 0;
    for (int k = 0; k < 20; k++) begin
      step("t6");
      check("t6_range7", (result7 >= 3'd1 && result7 <= 3'd7) ? 32'd1 : 32'd0, 32'd1);
      if (prev7 == 3'd7 && result7 == 3'd1) wraps7++;
      prev7 = result7;
    end
    check("t6_wrap_seen", (wraps7 >= 2) ? 32'd1 : 32'd0, 32'd1);

    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule
